seq_gen_serializer: RTL and testbench

//  Transmit end of the serial sequence-detect path: accepts a parallel bit pattern over a valid/ready

---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_shift_reg.sv | 28 ++
 rtl/seq_gen_serializer.sv | 134 +++++++++++++
 tb/tb_seq_gen_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding and default field widths.
package seq_gen_pkg;

  localparam int PATTERN_W_DEF = 4;
  localparam int REP_W_DEF     = 4;
  localparam int GAP_W_DEF     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register exposing its MSB; feeds the serial line.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load)       data_d = din;
    else if (shift) data_d = {data_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign msb = data_q[W-1];

endmodule

// File: rtl/seq_gen_serializer.sv
// Serializes a handshaken parallel pattern MSB-first, with programmable repeat count
// and idle gap between frames. FSM, counters and handshake live here.
module seq_gen_serializer
  import seq_gen_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF,
  parameter int REP_W     = REP_W_DEF,
  parameter int GAP_W     = GAP_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PATTERN_W-1:0] pat_data,
  input  logic [REP_W-1:0]     pat_repeat,
  input  logic [GAP_W-1:0]     pat_gap,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic                 abort,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(PATTERN_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PATTERN_W - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]     gap_cfg_q, gap_cfg_d;
  logic [REP_W-1:0]     rep_left_q, rep_left_d;
  logic [PATTERN_W-1:0] frame_q, frame_d;
  logic                 done_q, done_d;

  logic                 sr_load, sr_shift, sr_msb;
  logic [PATTERN_W-1:0] sr_din;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gap_cfg_d  = gap_cfg_q;
    rep_left_d = rep_left_q;
    frame_d    = frame_q;
    done_d     = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_din     = frame_q;
    unique case (state_q)
      IDLE: begin
        if (pat_valid) begin
          sr_load    = 1'b1;
          sr_din     = pat_data;
          frame_d    = pat_data;
          rep_left_d = (pat_repeat == '0) ? REP_W'(1) : pat_repeat;
          gap_cfg_d  = pat_gap;
          bit_cnt_d  = BIT_LAST;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // abort beats a coinciding last bit, so no done is raised
        if (abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q == '0) begin
          if (rep_left_q == REP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rep_left_d = rep_left_q - 1'b1;
            if (gap_cfg_q == '0) begin
              sr_load   = 1'b1;
              bit_cnt_d = BIT_LAST;
            end else begin
              gap_cnt_d = gap_cfg_q;
              state_d   = GAP;
            end
          end
        end else begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          sr_load   = 1'b1;
          bit_cnt_d = BIT_LAST;
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      gap_cfg_q  <= '0;
      rep_left_q <= '0;
      frame_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      gap_cfg_q  <= gap_cfg_d;
      rep_left_q <= rep_left_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
    end
  end

  seq_shift_reg #(.W(PATTERN_W)) u_sr (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  assign pat_ready = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == GAP);
  assign out_valid = (state_q == SHIFT);
  assign out_bit   = out_valid & sr_msb;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_serializer.sv
// Directed bench: a per-cycle expected-output queue built from the stream rules, plus literal checks.
module tb_seq_gen_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] pat_data = '0;
  logic [3:0] pat_repeat = '0;
  logic [2:0] pat_gap = '0;
  logic       pat_valid = 1'b0;
  logic       abort = 1'b0;
  logic       pat_ready, out_bit, out_valid, busy, done;

  seq_gen_serializer dut (
    .clk(clk), .reset(reset), .pat_data(pat_data), .pat_repeat(pat_repeat),
    .pat_gap(pat_gap), .pat_valid(pat_valid), .pat_ready(pat_ready), .abort(abort),
    .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic v; logic b; logic bz; logic dn; logic rdy;} exp_t;
  exp_t q[$];

  int nvec = 0, nerr = 0;
  int cyc, cap_n, done_cnt, done_cyc, first_v, gap_seen;
  logic [63:0] cap;

  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One stream = N frames of MSB-first bits, gap idle cycles between frames, then a done/ready cycle.
  task automatic push_stream(input logic [3:0] d, input int rep, input int gap);
    int n;
    n = (rep == 0) ? 1 : rep;
    for (int f = 0; f < n; f++) begin
      for (int b = 3; b >= 0; b--) q.push_back('{v:1'b1, b:d[b], bz:1'b1, dn:1'b0, rdy:1'b0});
      if (f < n - 1)
        for (int g = 0; g < gap; g++) q.push_back('{v:1'b0, b:1'b0, bz:1'b1, dn:1'b0, rdy:1'b0});
    end
    q.push_back('{v:1'b0, b:1'b0, bz:1'b0, dn:1'b1, rdy:1'b1});
  endtask

  task automatic clr_stats();
    cyc = 0; cap = '0; cap_n = 0; done_cnt = 0; done_cyc = -1; first_v = -1; gap_seen = 0;
  endtask

  // Sample at negedge, compare against the model, advance the model, then step past posedge.
  task automatic tick();
    exp_t e;
    cyc++;
    @(negedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      e = (q.size() > 0) ? q.pop_front() : '{v:1'b0, b:1'b0, bz:1'b0, dn:1'b0, rdy:1'b1};
      nvec++;
      if ({out_valid, out_bit, busy, done, pat_ready} !== {e.v, e.b, e.bz, e.dn, e.rdy}) begin
        nerr++;
        $display("FAIL stream cyc%0d: got v=%b b=%b busy=%b done=%b rdy=%b want v=%b b=%b busy=%b done=%b rdy=%b",
                 cyc, out_valid, out_bit, busy, done, pat_ready, e.v, e.b, e.bz, e.dn, e.rdy);
      end
      if (out_valid) begin
        cap = {cap[62:0], out_bit};
        cap_n++;
        if (first_v < 0) first_v = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!out_valid && busy) gap_seen++;
      if (abort && !e.rdy) q.delete();
      if (pat_valid && e.rdy) push_stream(pat_data, int'(pat_repeat), int'(pat_gap));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input int rep, input int gap);
    pat_data = d; pat_repeat = 4'(rep); pat_gap = 3'(gap); pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
    clr_stats();
  endtask

  task automatic wait_done(input int n, input int max);
    for (int i = 0; i < max && done_cnt < n; i++) tick();
    chk("done_reached", done_cnt, n);
  endtask

  initial begin
    clr_stats();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("rst_ready", pat_ready, 1);

    // 1) single frame 1011
    send(4'b1011, 1, 0);
    wait_done(1, 20);
    chk("t1_bits", int'(cap[3:0]), 4'b1011);
    chk("t1_nbits", cap_n, 4);
    chk("t1_first", first_v, 1);
    chk("t1_done_cyc", done_cyc, 5);

    // 2) 1111 x3 back-to-back
    send(4'b1111, 3, 0);
    wait_done(1, 30);
    chk("t2_bits", int'(cap[11:0]), 12'hFFF);
    chk("t2_nbits", cap_n, 12);
    chk("t2_done_cyc", done_cyc, 13);
    repeat (3) tick();
    chk("t2_single_done", done_cnt, 1);

    // 3) 1011 x2 with gap 2
    send(4'b1011, 2, 2);
    wait_done(1, 30);
    chk("t3_bits", int'(cap[7:0]), 8'b1011_1011);
    chk("t3_gap", gap_seen, 2);
    chk("t3_done_cyc", done_cyc, 11);

    // 4) repeat=0 sends one frame; queued request waits for the done cycle
    send(4'b0110, 0, 0);
    pat_data = 4'b1001; pat_repeat = 4'd1; pat_gap = 3'd0;
    tick();
    pat_valid = 1'b1;
    for (int i = 0; i < 20 && done_cnt < 1; i++) tick();
    pat_valid = 1'b0;
    wait_done(2, 20);
    chk("t4_bits", int'(cap[7:0]), 8'b0110_1001);
    chk("t4_nbits", cap_n, 8);
    chk("t4_done_cyc", done_cyc, 10);

    // 5) reset mid-frame after two bits
    send(4'b1011, 1, 0);
    tick(); tick();
    chk("t5_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_bit", out_bit, 0);
    chk("t5_async_busy", busy, 0);
    tick(); tick();
    reset = 1'b1;
    clr_stats();
    repeat (3) tick();
    chk("t5_no_done", done_cnt, 0);
    send(4'b1101, 1, 0);
    wait_done(1, 20);
    chk("t5_bits", int'(cap[3:0]), 4'b1101);

    // 6) abort in GAP of a 3-frame stream
    send(4'b1011, 3, 3);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (10) tick();
    chk("t6_nbits", cap_n, 4);
    chk("t6_no_done", done_cnt, 0);

    // abort coinciding with the last bit suppresses done
    send(4'b0101, 1, 0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    chk("t7_nbits", cap_n, 4);
    chk("t7_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
